// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used when a request is accepted.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      READ  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_e;

   // The reserved size is reported as misaligned so it never reaches the RAM.
   function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return offset[0];
         SZ_WORD: return |offset;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: extracts and extends the addressed byte/half of a
// RAM word for loads, and merges store data into the old word for stores.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] rdata,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      byte_sel  = rdata[{offset, 3'b000} +: 8];
      half_sel  = rdata[{offset[1], 4'b0000} +: 16];
      load_data = rdata;
      case (size)
         SZ_BYTE: load_data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
         SZ_HALF: load_data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
         default: load_data = rdata;
      endcase
   end

   always_comb begin
      merged = wdata;
      case (size)
         SZ_BYTE: begin
            merged = old_word;
            merged[{offset, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            merged = old_word;
            merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-wide asynchronous-read
// RAM; sub-word stores are done as read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [DATAWIDTH-1:0] req_addr,
   input  logic [DATAWIDTH-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [DATAWIDTH-1:0] resp_rdata,
   output logic                 resp_err,
   output logic                 ram_ena,
   output logic                 ram_wen,
   output logic [DATAWIDTH-1:0] ram_addr,
   output logic [DATAWIDTH-1:0] ram_din,
   input  logic [DATAWIDTH-1:0] ram_dout
);

   state_e                 state;
   logic                   r_we;
   size_e                  r_size;
   logic                   r_unsigned;
   logic [DATAWIDTH-1:0]   r_addr;
   logic [DATAWIDTH-1:0]   r_wdata;
   logic [DATAWIDTH-1:0]   old_word;
   logic [DATAWIDTH-1:0]   load_data;
   logic [DATAWIDTH-1:0]   merged;

   assign req_ready = (state == IDLE) && !rst;

   // Address and write word are pure functions of captured registers, so they
   // stay stable through IDLE and RESP without extra storage.
   assign ram_addr = {2'b00, r_addr[DATAWIDTH-1:2]};
   assign ram_din  = merged;

   lsu_byte_lane u_lane (
      .size        (r_size),
      .offset      (r_addr[1:0]),
      .is_unsigned (r_unsigned),
      .rdata       (ram_dout),
      .old_word    (old_word),
      .wdata       (r_wdata),
      .load_data   (load_data),
      .merged      (merged)
   );

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: every register, including the captured request and old word, is cleared so an aborted access leaves nothing behind.
         state      <= IDLE;
         r_we       <= 1'b0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         old_word   <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         ram_ena    <= 1'b0;
         ram_wen    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_size     <= size_e'(req_size);
                  r_unsigned <= req_unsigned;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  if (is_misaligned(size_e'(req_size), req_addr[1:0])) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (!req_we) begin
                     state   <= LOAD;
                     ram_ena <= 1'b1;
                  end else if (size_e'(req_size) == SZ_WORD) begin
                     state   <= WRITE;
                     ram_ena <= 1'b1;
                     ram_wen <= 1'b1;
                  end else begin
                     state   <= READ;
                     ram_ena <= 1'b1;
                  end
               end
            end
            LOAD: begin
               resp_rdata <= load_data;
               resp_valid <= 1'b1;
               ram_ena    <= 1'b0;
               state      <= RESP;
            end
            READ: begin
               old_word <= ram_dout;
               ram_wen  <= r_we;
               state    <= WRITE;
            end
            WRITE: begin
               ram_ena    <= 1'b0;
               ram_wen    <= 1'b0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               ram_ena    <= 1'b0;
               ram_wen    <= 1'b0;
               resp_valid <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
